counter_wrap_tracker: RTL and testbench
=======================================

# counter_wrap_tracker

Downstream consumer of the 4-bit up-counter's `counter_out` stream. The block detects every 15→0 wrap, extends the count into a wider epoch counter, and queues one interrupt request per wrap over a four-phase req/ack handshake. It also flags illegal count sequences. It sits between the counter and the interrupt/status logic.

## Interface
- `EPOCH_W`, 8: width of the epoch (wrap) counter.
- `PEND_W`, 3: width of the pending-event counter; PEND_MAX = 2^PEND_W − 1.
- `EPOCH_SAT`, 0: 1 = epoch counter saturates at all-ones; 0 = epoch counter wraps to 0.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `count_in`  in  4  counter value, sampled every cycle.
- `irq_ack`  in  1  interrupt acknowledge from the consumer.
- `wrap_pulse`  out  1  one-cycle pulse per detected wrap.
- `epoch_count`  out  EPOCH_W  number of wraps since reset.
- `irq_req`  out  1  interrupt request (four-phase).
- `pending`  out  PEND_W  wraps not yet acknowledged.
- `drop_err`  out  1  sticky: a wrap arrived while `pending` == PEND_MAX.
- `seq_err`  out  1  sticky: illegal `count_in` step.

## Operation
- Sampling:
  - `prev_count` is registered from `count_in` every cycle.
  - `hist_valid` clears on reset and sets after the first post-reset sample.
  - No comparison is made while `hist_valid` = 0.
- Wrap detection: a wrap is `hist_valid` && `prev_count` == 4'hF && `count_in` == 4'h0.
- Legal steps:
  - `count_in` == `prev_count`, or `count_in` == `prev_count` + 1 mod 16.
  - Any other step sets `seq_err`. It is not counted as a wrap.
- Epoch counter:
  - Increments by 1 per wrap, modulo 2^EPOCH_W.
  - If EPOCH_SAT = 1, it holds at all-ones instead.
- Pending counter:
  - +1 per wrap, −1 per accepted ack.
  - Simultaneous wrap and ack leaves it unchanged.
  - A wrap arriving at PEND_MAX with no ack in the same cycle keeps `pending` at PEND_MAX and sets `drop_err`.
- Handshake FSM, three states:
  - IDLE: `irq_req` = 0. Goes to REQ when `pending` ≠ 0.
  - REQ: `irq_req` = 1. When `irq_ack` = 1, the ack is accepted (pending −1) and the FSM goes to ACKED.
  - ACKED: `irq_req` = 0. Waits for `irq_ack` = 0, then goes to IDLE.
  - `irq_ack` seen in IDLE or ACKED is ignored. It is never counted.
- Sticky flags clear only on reset.

## Timing
- Reset values:
  - All outputs are 0: `wrap_pulse`, `epoch_count`, `irq_req`, `pending`, `drop_err`, `seq_err`.
  - FSM is IDLE, `prev_count` is 0, `hist_valid` is 0.
- Reset mid-handshake: the FSM returns to IDLE and `irq_req` drops on the next edge. Outstanding pending events are discarded.
- Wrap latency: when edge N samples `count_in` = 0 after F, then after edge N:
  - `wrap_pulse` is high for exactly one cycle.
  - `epoch_count` and `pending` show their updated values.
- `irq_req` rises at edge N+1 if the FSM was IDLE, giving 2 cycles from the sampled 0 to `irq_req`.
- Ack acceptance: `irq_ack` sampled high in REQ at edge M gives, after edge M, `irq_req` = 0 and `pending` decremented.
- Back-to-back events: the minimum full cycle is REQ → ACKED → IDLE → REQ, i.e. 3 edges with ack held 1 cycle.
- Counter held (no enable): repeated F samples are not wraps. A repeated 0 after a wrap is not a second wrap.

## Structure
- Package `counter_wrap_pkg` holds:
  - `COUNT_W` = 4 and `COUNT_MAX` = 4'hF.
  - FSM state enum `wrap_irq_state_t` {IDLE, REQ, ACKED}.
- Sub-module `count_wrap_detect` holds:
  - `prev_count`, `hist_valid`, and the wrap/`seq_err` comparison logic.
  - Outputs: registered `wrap_pulse` and a `step_err` pulse.
- The top level holds the epoch counter, pending counter, FSM and sticky flags.

## Test plan
- Reset, then `count_in` ramps 0..F,0 with `irq_ack` tied 0:
  - `wrap_pulse` fires once, 1 cycle after 0 is sampled.
  - `epoch_count` = 1, `pending` = 1.
  - `irq_req` = 1 on the next cycle and stays high.
- Ack `irq_ack` for 1 cycle while `irq_req` = 1:
  - `irq_req` = 0 and `pending` = 0 the cycle after.
  - Holding ack high 5 cycles produces no second decrement.
- 9 wraps with no ack at PEND_W = 3:
  - `pending` saturates at 7 and `drop_err` = 1.
  - `epoch_count` = 9.
- Wrap and ack accepted in the same cycle with `pending` = 2: `pending` stays 2 and `epoch_count` increments.
- `count_in` sequence 3,4,9: `seq_err` = 1 and stays set; no `wrap_pulse`.
- Assert reset while in REQ with `pending` = 3: next cycle all outputs are 0; the first sample after reset raises no `seq_err`.

Source files
------------

// File: rtl/counter_wrap_pkg.sv
// Shared definitions for the counter wrap tracker.
//   COUNT_W / COUNT_MAX : width and terminal value of the upstream 4-bit counter
//   wrap_irq_state_t    : interrupt handshake states (IDLE, REQ, ACKED)
//   count_next()        : modulo-16 successor of a counter value
package counter_wrap_pkg;

    localparam int COUNT_W = 4;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACKED = 2'd2
    } wrap_irq_state_t;

    // Successor value of the upstream counter; the natural width overflow
    // gives the 15 -> 0 wrap.
    function automatic logic [COUNT_W-1:0] count_next(input logic [COUNT_W-1:0] c);
        return c + 1'b1;
    endfunction

endpackage

// File: rtl/count_wrap_detect.sv
// Sample-history and step checker for the upstream counter stream.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   count_in    : counter value, sampled every cycle
//   wrap_hit    : combinational, the current sample completes a 15 -> 0 wrap
//   wrap_pulse  : registered, one-cycle pulse after the edge that saw the wrap
//   step_err    : combinational pulse, the current sample is an illegal step
module count_wrap_detect
    import counter_wrap_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [COUNT_W-1:0] count_in,
    output logic               wrap_hit,
    output logic               wrap_pulse,
    output logic               step_err
);

    logic [COUNT_W-1:0] prev_count;
    logic               hist_valid;
    logic               step_legal;

    // Nothing is compared until one post-reset sample has been captured, so
    // the first value after reset can be anything without raising an error.
    always_comb begin
        step_legal = (count_in == prev_count) || (count_in == count_next(prev_count));
        wrap_hit   = hist_valid && (prev_count == COUNT_MAX) && (count_in == '0);
        step_err   = hist_valid && !step_legal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_count <= '0;
            hist_valid <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            prev_count <= count_in;
            hist_valid <= 1'b1;
            wrap_pulse <= wrap_hit;
        end
    end

endmodule

// File: rtl/counter_wrap_tracker.sv
// Tracks wraps of the upstream 4-bit counter and raises one four-phase
// interrupt request per wrap.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   count_in     : counter value, sampled every cycle
//   irq_ack      : interrupt acknowledge from the consumer
//   wrap_pulse   : one-cycle pulse per detected wrap
//   epoch_count  : wraps since reset (wraps or saturates per EPOCH_SAT)
//   irq_req      : interrupt request
//   pending      : wraps not yet acknowledged
//   drop_err     : sticky, a wrap arrived with pending already full
//   seq_err      : sticky, an illegal count step was seen
//   irq_state    : current handshake state, for observation
// Handshake: irq_req is high only in REQ. An ack is accepted only in REQ
// (irq_ack high at the edge), which drops irq_req and decrements pending;
// the request is not re-raised until irq_ack has been seen low again.
module counter_wrap_tracker
    import counter_wrap_pkg::*;
#(
    parameter int EPOCH_W   = 8,
    parameter int PEND_W    = 3,
    parameter bit EPOCH_SAT = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COUNT_W-1:0] count_in,
    input  logic               irq_ack,
    output logic               wrap_pulse,
    output logic [EPOCH_W-1:0] epoch_count,
    output logic               irq_req,
    output logic [PEND_W-1:0]  pending,
    output logic               drop_err,
    output logic               seq_err,
    output wrap_irq_state_t    irq_state
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic            wrap_hit;
    logic            step_err;
    logic            ack_accept;
    wrap_irq_state_t state;
    wrap_irq_state_t state_next;

    count_wrap_detect u_detect (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .wrap_hit   (wrap_hit),
        .wrap_pulse (wrap_pulse),
        .step_err   (step_err)
    );

    assign ack_accept = (state == REQ) && irq_ack;

    // Epoch counter: updated on the same edge that samples the wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            epoch_count <= '0;
        end else if (wrap_hit) begin
            if (!(EPOCH_SAT && (&epoch_count))) begin
                epoch_count <= epoch_count + 1'b1;
            end
        end
    end

    // Pending counter and sticky flags. A wrap and an accepted ack in the
    // same cycle cancel, so a full counter only drops when no ack arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            drop_err <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            unique case ({wrap_hit, ack_accept})
                2'b10: begin
                    if (pending == PEND_MAX) begin
                        drop_err <= 1'b1;
                    end else begin
                        pending <= pending + 1'b1;
                    end
                end
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
            if (step_err) begin
                seq_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        irq_req    = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending != '0) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                irq_req = 1'b1;
                if (irq_ack) begin
                    state_next = ACKED;
                end
            end
            ACKED: begin
                if (!irq_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign irq_state = state;

endmodule

// File: tb/tb_counter_wrap_tracker.sv
module tb_counter_wrap_tracker;

  localparam int W = 15;  // {wrap_pulse, epoch[7:0], irq_req, pending[2:0], drop_err, seq_err}

  logic       clk;
  logic       reset;
  logic [3:0] count_in;
  logic       irq_ack;
  logic       wrap_pulse;
  logic [7:0] epoch_count;
  logic       irq_req;
  logic [2:0] pending;
  logic       drop_err;
  logic       seq_err;
  counter_wrap_pkg::wrap_irq_state_t irq_state;

  counter_wrap_tracker #(.EPOCH_W(8), .PEND_W(3), .EPOCH_SAT(1'b0)) dut (
    .clk         (clk),
    .reset       (reset),
    .count_in    (count_in),
    .irq_ack     (irq_ack),
    .wrap_pulse  (wrap_pulse),
    .epoch_count (epoch_count),
    .irq_req     (irq_req),
    .pending     (pending),
    .drop_err    (drop_err),
    .seq_err     (seq_err),
    .irq_state   (irq_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [7:0]   wrap_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // reference model state (behavioural, integer arithmetic)
  int m_prev, m_epoch, m_pend;
  bit m_hist, m_drop, m_seq, m_wp;
  bit m_requesting;   // request outstanding, waiting for ack
  bit m_wait_release; // ack accepted, waiting for ack to drop
  int cur;

  task automatic model_step(input bit r, input int c, input bit a);
    bit wrap, legal, accept;
    int p;
    if (r) begin
      m_prev = 0; m_hist = 0; m_epoch = 0; m_pend = 0;
      m_drop = 0; m_seq = 0; m_wp = 0;
      m_requesting = 0; m_wait_release = 0;
    end else begin
      wrap   = m_hist && m_prev == 15 && c == 0;
      legal  = (c == m_prev) || (c == (m_prev + 1) % 16);
      accept = m_requesting && a;
      // handshake progression uses the pending count before this edge
      if (m_requesting) begin
        if (a) begin m_requesting = 0; m_wait_release = 1; end
      end else if (m_wait_release) begin
        if (!a) m_wait_release = 0;
      end else if (m_pend != 0) begin
        m_requesting = 1;
      end
      p = m_pend + (wrap ? 1 : 0) - (accept ? 1 : 0);
      if (p > 7) begin p = 7; m_drop = 1; end
      m_pend = p;
      if (wrap) m_epoch = (m_epoch + 1) % 256;
      if (m_hist && !legal) m_seq = 1;
      m_wp = wrap;
      m_prev = c;
      m_hist = 1;
      if (wrap) wrap_q.push_back(8'(m_epoch));
    end
  endtask

  // driver: apply one cycle of inputs, push the expected post-edge outputs
  task automatic step(input int c, input bit a, input bit r);
    logic [W-1:0] e;
    count_in = 4'(c);
    irq_ack  = a;
    reset    = r;
    model_step(r, c, a);
    e = {m_wp, 8'(m_epoch), m_requesting, 3'(m_pend), m_drop, m_seq};
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic ramp(input int n, input bit a);
    repeat (n) begin
      cur = (cur + 1) % 16;
      step(cur, a, 1'b0);
    end
  endtask

  // monitor: compare on the falling edge, away from the active edge
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    logic [7:0]   ee;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {wrap_pulse, epoch_count, irq_req, pending, drop_err, seq_err};
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t: actual wp=%b epoch=%0d req=%b pend=%0d drop=%b seq=%b, required wp=%b epoch=%0d req=%b pend=%0d drop=%b seq=%b",
                 $time, act[14], act[13:6], act[5], act[4:2], act[1], act[0],
                 e[14], e[13:6], e[5], e[4:2], e[1], e[0]);
      end
    end
    if (wrap_pulse === 1'b1) begin
      n_checks++;
      if (wrap_q.size() == 0) begin
        n_fail++;
        $display("FAIL wrap_event @%0t: actual unexpected wrap_pulse, required no wrap", $time);
      end else begin
        ee = wrap_q.pop_front();
        if (epoch_count !== ee) begin
          n_fail++;
          $display("FAIL wrap_epoch @%0t: actual %0d, required %0d", $time, epoch_count, ee);
        end
      end
    end
  end

  initial begin
    int r;
    count_in = 4'h0; irq_ack = 1'b0; reset = 1'b1;
    cur = 0;

    // reset, then one full ramp ending in a wrap; ack held low
    step(0, 0, 1); step(0, 0, 1);
    step(0, 0, 0);
    ramp(16, 0);
    repeat (3) step(0, 0, 0);          // repeated 0 is not a second wrap

    // ack for five cycles: exactly one decrement
    repeat (5) step(0, 1, 0);
    repeat (3) step(0, 0, 0);

    // nine wraps without ack, with held F samples
    step(0, 0, 1); cur = 0; step(0, 0, 0);
    repeat (9) begin
      ramp(15, 0);
      step(15, 0, 0); step(15, 0, 0);
      ramp(1, 0);
    end
    repeat (2) step(0, 0, 0);

    // wrap and accepted ack in the same cycle with pending = 2
    step(0, 0, 1); cur = 0; step(0, 0, 0);
    ramp(16, 0); ramp(16, 0);
    repeat (3) step(0, 0, 0);
    ramp(15, 0);
    cur = 0; step(0, 1, 0);
    repeat (2) step(0, 0, 0);

    // illegal step 3,4,9
    step(3, 0, 0); step(4, 0, 0); step(9, 0, 0); step(10, 0, 0);
    cur = 10;

    // reset while requesting with pending = 3; first sample after reset is arbitrary
    step(0, 0, 1); cur = 0; step(0, 0, 0);
    ramp(16, 0); ramp(16, 0); ramp(16, 0);
    repeat (2) step(0, 0, 0);
    step(0, 0, 1);
    step(7, 0, 0); step(8, 0, 0);
    cur = 8;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        step(cur, 0, 1);
      end else begin
        r = $urandom_range(0, 99);
        if (r < 40)      cur = cur;
        else if (r < 97) cur = (cur + 1) % 16;
        else             cur = $urandom_range(0, 15);
        step(cur, ($urandom_range(0, 3) == 0), 0);
      end
    end

    // drain and completeness
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual %0d expectations left, required 0", exp_q.size());
    end
    n_checks++;
    if (wrap_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_wraps: actual %0d wraps unseen, required 0", wrap_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
